// File: rtl/ctrl_decode_path_pkg.sv
// Shared constants and types for the ARM-subset control path: ALU opcodes,
// addressing modes, instruction classes, control bundle and mnemonic constants.
package ctrl_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_EOR = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_RSB = 4'b0011;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_ADC = 4'b0101;
    localparam logic [3:0] ALU_SBC = 4'b0110;
    localparam logic [3:0] ALU_RSC = 4'b0111;
    localparam logic [3:0] ALU_TST = 4'b1000;
    localparam logic [3:0] ALU_TEQ = 4'b1001;
    localparam logic [3:0] ALU_CMP = 4'b1010;
    localparam logic [3:0] ALU_CMN = 4'b1011;
    localparam logic [3:0] ALU_ORR = 4'b1100;
    localparam logic [3:0] ALU_MOV = 4'b1101;
    localparam logic [3:0] ALU_BIC = 4'b1110;
    localparam logic [3:0] ALU_MVN = 4'b1111;

    localparam logic [1:0] AM_IMM    = 2'b00;
    localparam logic [1:0] AM_REG    = 2'b01;
    localparam logic [1:0] AM_SHIFT  = 2'b10;
    localparam logic [1:0] AM_REGOFF = 2'b11;

    localparam logic [2:0] CLS_DP_REG = 3'b000;
    localparam logic [2:0] CLS_DP_IMM = 3'b001;
    localparam logic [2:0] CLS_LS_IMM = 3'b010;
    localparam logic [2:0] CLS_LS_REG = 3'b011;
    localparam logic [2:0] CLS_BRANCH = 3'b101;

    localparam int KW_CHARS_DEF  = 6;
    localparam int KW_BASE_CHARS = 6;

    localparam logic [47:0] KW_NOP   = 48'("NOP   ");
    localparam logic [47:0] KW_UNDEF = 48'("UNDEF ");
    localparam logic [47:0] KW_LDR   = 48'("LDR   ");
    localparam logic [47:0] KW_LDRB  = 48'("LDRB  ");
    localparam logic [47:0] KW_STR   = 48'("STR   ");
    localparam logic [47:0] KW_STRB  = 48'("STRB  ");
    localparam logic [47:0] KW_B     = 48'("B     ");
    localparam logic [47:0] KW_BL    = 48'("BL    ");

    typedef struct packed {
        logic [3:0] opcode;
        logic [1:0] am;
        logic       s_enable;
        logic       load_instr;
        logic       rf_enable;
        logic       size_enable;
        logic       rw_enable;
        logic       enable_signal;
        logic       bl_instr;
        logic       b_instr;
    } ctrl_t;

    function automatic logic [47:0] dp_keyword(input logic [3:0] op);
        logic [47:0] kw;
        case (op)
            ALU_AND: kw = 48'("AND   ");
            ALU_EOR: kw = 48'("EOR   ");
            ALU_SUB: kw = 48'("SUB   ");
            ALU_RSB: kw = 48'("RSB   ");
            ALU_ADD: kw = 48'("ADD   ");
            ALU_ADC: kw = 48'("ADC   ");
            ALU_SBC: kw = 48'("SBC   ");
            ALU_RSC: kw = 48'("RSC   ");
            ALU_TST: kw = 48'("TST   ");
            ALU_TEQ: kw = 48'("TEQ   ");
            ALU_CMP: kw = 48'("CMP   ");
            ALU_CMN: kw = 48'("CMN   ");
            ALU_ORR: kw = 48'("ORR   ");
            ALU_MOV: kw = 48'("MOV   ");
            ALU_BIC: kw = 48'("BIC   ");
            ALU_MVN: kw = 48'("MVN   ");
            default: kw = KW_UNDEF;
        endcase
        return kw;
    endfunction

endpackage

// File: rtl/ctrl_decode_path_decoder.sv
// Combinational instruction decoder: controls plus optional ASCII mnemonic.
// Mnemonic ROM is built only when CTRL_KEYWORD_EN is defined.
module ctrl_decoder
    import ctrl_pkg::*;
#(
    parameter int KW_CHARS = KW_CHARS_DEF
) (
    input  logic [31:0]           instruction,
    output ctrl_t                 ctrl,
    output logic [8*KW_CHARS-1:0] keyword
);

    ctrl_t ctrl_s;

    // Control decode; the all-zero word is a NOP rather than AND r0,r0,r0.
    always_comb begin
        ctrl_s = '0;
        if (instruction == 32'h0000_0000) begin
            ctrl_s = '0;
        end else begin
            case (instruction[27:25])
                CLS_DP_REG, CLS_DP_IMM: begin
                    ctrl_s.opcode    = instruction[24:21];
                    ctrl_s.s_enable  = instruction[20];
                    ctrl_s.rf_enable = (instruction[24:23] != 2'b10);
                    if (instruction[25]) begin
                        ctrl_s.am = AM_IMM;
                    end else if (instruction[11:4] == 8'h00) begin
                        ctrl_s.am = AM_REG;
                    end else begin
                        ctrl_s.am = AM_SHIFT;
                    end
                end
                CLS_LS_IMM, CLS_LS_REG: begin
                    ctrl_s.enable_signal = 1'b1;
                    ctrl_s.load_instr    = instruction[20];
                    ctrl_s.rf_enable     = instruction[20];
                    ctrl_s.rw_enable     = ~instruction[20];
                    ctrl_s.size_enable   = instruction[22];
                    ctrl_s.opcode        = instruction[23] ? ALU_ADD : ALU_SUB;
                    ctrl_s.am            = instruction[25] ? AM_REGOFF : AM_SHIFT;
                end
                CLS_BRANCH: begin
                    ctrl_s.b_instr   = 1'b1;
                    ctrl_s.bl_instr  = instruction[24];
                    ctrl_s.rf_enable = instruction[24];
                end
                default: ctrl_s = '0;
            endcase
        end
    end

    assign ctrl = ctrl_s;

`ifdef CTRL_KEYWORD_EN
    logic [47:0]           mn_s;
    logic [8*KW_CHARS-1:0] kw_s;

    // Mnemonic selection mirrors the class decode above.
    always_comb begin
        mn_s = KW_UNDEF;
        if (instruction == 32'h0000_0000) begin
            mn_s = KW_NOP;
        end else begin
            case (instruction[27:25])
                CLS_DP_REG, CLS_DP_IMM: mn_s = dp_keyword(instruction[24:21]);
                CLS_LS_IMM, CLS_LS_REG: begin
                    if (instruction[20]) begin
                        mn_s = instruction[22] ? KW_LDRB : KW_LDR;
                    end else begin
                        mn_s = instruction[22] ? KW_STRB : KW_STR;
                    end
                end
                CLS_BRANCH: mn_s = instruction[24] ? KW_BL : KW_B;
                default:    mn_s = KW_UNDEF;
            endcase
        end
    end

    // Left-justify into KW_CHARS characters, padding with spaces or truncating.
    always_comb begin
        kw_s = '0;
        for (int i = 0; i < KW_CHARS; i++) begin
            if (i < KW_BASE_CHARS) begin
                kw_s[8*(KW_CHARS-1-i) +: 8] = mn_s[8*(KW_BASE_CHARS-1-i) +: 8];
            end else begin
                kw_s[8*(KW_CHARS-1-i) +: 8] = 8'h20;
            end
        end
    end

    assign keyword = kw_s;
`else
    assign keyword = {(8*KW_CHARS){1'b0}};
`endif

endmodule

// File: rtl/ctrl_decode_path.sv
// ID-stage control path: decoder, bubble mux and the EX/MEM control register.
// Define CTRL_KEYWORD_EN to build the ASCII mnemonic output.
module ctrl_decode_path
    import ctrl_pkg::*;
#(
    parameter int KW_CHARS = KW_CHARS_DEF
) (
    input  logic                  clk,
    input  logic                  R,
    input  logic [31:0]           instruction,
    input  logic                  S,
    output logic [3:0]            ID_opcode,
    output logic [1:0]            ID_AM,
    output logic                  ID_S_enable,
    output logic                  ID_load_instr,
    output logic                  ID_RF_enable,
    output logic                  ID_Size_enable,
    output logic                  ID_RW_enable,
    output logic                  ID_Enable_signal,
    output logic                  ID_BL_instr,
    output logic                  ID_B_instr,
    output logic [8*KW_CHARS-1:0] keyword,
    input  logic                  in_EX_load_instr,
    input  logic                  in_EX_RF_enable,
    input  logic                  in_EX_Size_enable,
    input  logic                  in_EX_RW_enable,
    input  logic                  in_EX_Enable_signal,
    output logic                  MEM_load_instr,
    output logic                  MEM_RF_enable,
    output logic                  MEM_Size_enable,
    output logic                  MEM_RW_enable,
    output logic                  MEM_Enable_signal
);

    ctrl_t      dec_ctrl_s;
    ctrl_t      id_ctrl_s;
    logic [4:0] mem_ctrl_r;

    ctrl_decoder #(
        .KW_CHARS (KW_CHARS)
    ) u_decoder (
        .instruction (instruction),
        .ctrl        (dec_ctrl_s),
        .keyword     (keyword)
    );

    // Bubble mux: S squashes every ID control to zero; the keyword is not muxed.
    always_comb begin
        id_ctrl_s = '0;
        if (S) begin
            id_ctrl_s = '0;
        end else begin
            id_ctrl_s = dec_ctrl_s;
        end
    end

    assign ID_opcode        = id_ctrl_s.opcode;
    assign ID_AM            = id_ctrl_s.am;
    assign ID_S_enable      = id_ctrl_s.s_enable;
    assign ID_load_instr    = id_ctrl_s.load_instr;
    assign ID_RF_enable     = id_ctrl_s.rf_enable;
    assign ID_Size_enable   = id_ctrl_s.size_enable;
    assign ID_RW_enable     = id_ctrl_s.rw_enable;
    assign ID_Enable_signal = id_ctrl_s.enable_signal;
    assign ID_BL_instr      = id_ctrl_s.bl_instr;
    assign ID_B_instr       = id_ctrl_s.b_instr;

    // EX/MEM control register, captured every edge, cleared asynchronously by R.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            mem_ctrl_r <= 5'b0_0000;
        end else begin
            mem_ctrl_r <= {in_EX_load_instr, in_EX_RF_enable, in_EX_Size_enable,
                           in_EX_RW_enable, in_EX_Enable_signal};
        end
    end

    assign MEM_load_instr    = mem_ctrl_r[4];
    assign MEM_RF_enable     = mem_ctrl_r[3];
    assign MEM_Size_enable   = mem_ctrl_r[2];
    assign MEM_RW_enable     = mem_ctrl_r[1];
    assign MEM_Enable_signal = mem_ctrl_r[0];

endmodule

// File: tb/tb_ctrl_decode_path.sv
// Directed bench for ctrl_decode_path: decode vectors, bubble mux and EX/MEM register.
// Keyword expectations follow CTRL_KEYWORD_EN (all zeros when undefined).
module tb_ctrl_decode_path;

`ifdef CTRL_KEYWORD_EN
    localparam bit KW_ON = 1'b1;
`else
    localparam bit KW_ON = 1'b0;
`endif

    logic        clk;
    logic        R;
    logic [31:0] instruction;
    logic        S;
    logic [3:0]  ID_opcode;
    logic [1:0]  ID_AM;
    logic        ID_S_enable, ID_load_instr, ID_RF_enable, ID_Size_enable;
    logic        ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr;
    logic [47:0] keyword;
    logic        in_EX_load_instr, in_EX_RF_enable, in_EX_Size_enable;
    logic        in_EX_RW_enable, in_EX_Enable_signal;
    logic        MEM_load_instr, MEM_RF_enable, MEM_Size_enable;
    logic        MEM_RW_enable, MEM_Enable_signal;

    int n_vec = 0;
    int n_err = 0;

    ctrl_decode_path #(.KW_CHARS(6)) dut (
        .clk                 (clk),
        .R                   (R),
        .instruction         (instruction),
        .S                   (S),
        .ID_opcode           (ID_opcode),
        .ID_AM               (ID_AM),
        .ID_S_enable         (ID_S_enable),
        .ID_load_instr       (ID_load_instr),
        .ID_RF_enable        (ID_RF_enable),
        .ID_Size_enable      (ID_Size_enable),
        .ID_RW_enable        (ID_RW_enable),
        .ID_Enable_signal    (ID_Enable_signal),
        .ID_BL_instr         (ID_BL_instr),
        .ID_B_instr          (ID_B_instr),
        .keyword             (keyword),
        .in_EX_load_instr    (in_EX_load_instr),
        .in_EX_RF_enable     (in_EX_RF_enable),
        .in_EX_Size_enable   (in_EX_Size_enable),
        .in_EX_RW_enable     (in_EX_RW_enable),
        .in_EX_Enable_signal (in_EX_Enable_signal),
        .MEM_load_instr      (MEM_load_instr),
        .MEM_RF_enable       (MEM_RF_enable),
        .MEM_Size_enable     (MEM_Size_enable),
        .MEM_RW_enable       (MEM_RW_enable),
        .MEM_Enable_signal   (MEM_Enable_signal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
        n_vec++;
        if (observed !== expected) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [47:0] exp_kw(input logic [47:0] s);
        return KW_ON ? s : 48'h0;
    endfunction

    // {opcode, AM, S, load, RF, size, RW, enable, BL, B}
    function automatic logic [13:0] id_bus();
        return {ID_opcode, ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable,
                ID_Size_enable, ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr};
    endfunction

    function automatic logic [4:0] mem_bus();
        return {MEM_load_instr, MEM_RF_enable, MEM_Size_enable, MEM_RW_enable,
                MEM_Enable_signal};
    endfunction

    task automatic apply_decode(input string tag, input logic [31:0] instr,
                                input logic sel, input logic [13:0] exp_id,
                                input logic [47:0] exp_k);
        instruction = instr;
        S = sel;
        #1;
        check_val({tag, "_id"}, 64'(id_bus()), 64'(exp_id));
        check_val({tag, "_kw"}, 64'(keyword), 64'(exp_kw(exp_k)));
    endtask

    initial begin
        R = 1'b0;
        S = 1'b0;
        instruction = 32'h0;
        {in_EX_load_instr, in_EX_RF_enable, in_EX_Size_enable,
         in_EX_RW_enable, in_EX_Enable_signal} = 5'b1_1111;

        // Decoder / mux vectors, independent of R.
        apply_decode("add_imm",  32'hE282_1005, 1'b0, 14'b0100_00_0_0_1_0_0_0_0_0, "ADD   ");
        apply_decode("cmp_reg",  32'hE151_0002, 1'b0, 14'b1010_01_1_0_0_0_0_0_0_0, "CMP   ");
        apply_decode("add_shft", 32'hE082_1103, 1'b0, 14'b0100_10_0_0_1_0_0_0_0_0, "ADD   ");
        apply_decode("ldrb",     32'hE5D4_3008, 1'b0, 14'b0100_10_0_1_1_1_0_1_0_0, "LDRB  ");
        apply_decode("str_reg",  32'hE704_3005, 1'b0, 14'b0010_11_0_0_0_0_1_1_0_0, "STR   ");
        apply_decode("bl",       32'hEB00_0004, 1'b0, 14'b0000_00_0_0_1_0_0_0_1_1, "BL    ");
        apply_decode("bl_bubl",  32'hEB00_0004, 1'b1, 14'b0,                        "BL    ");
        apply_decode("b",        32'hEA00_0004, 1'b0, 14'b0000_00_0_0_0_0_0_0_0_1, "B     ");
        apply_decode("undef",    32'hEC00_0000, 1'b0, 14'b0,                        "UNDEF ");
        apply_decode("nop",      32'h0000_0000, 1'b0, 14'b0,                        "NOP   ");
        apply_decode("ldrb_bub", 32'hE5D4_3008, 1'b1, 14'b0,                        "LDRB  ");

        // EX/MEM register: held clear while R is low.
        repeat (2) @(posedge clk);
        #1;
        check_val("mem_in_reset", 64'(mem_bus()), 64'h0);
        @(negedge clk);
        R = 1'b1;
        #1;
        check_val("mem_after_release_noedge", 64'(mem_bus()), 64'h0);
        @(posedge clk);
        #1;
        check_val("mem_first_capture", 64'(mem_bus()), 64'(5'b1_1111));
        @(negedge clk);
        in_EX_RW_enable = 1'b0;
        #1;
        check_val("mem_hold_until_edge", 64'(mem_bus()), 64'(5'b1_1111));
        @(posedge clk);
        #1;
        check_val("mem_rw_low", 64'(mem_bus()), 64'(5'b1_1101));
        #2;
        R = 1'b0;
        #1;
        check_val("mem_async_clear", 64'(mem_bus()), 64'h0);
        @(negedge clk);
        R = 1'b1;
        {in_EX_load_instr, in_EX_RF_enable, in_EX_Size_enable,
         in_EX_RW_enable, in_EX_Enable_signal} = 5'b0_1010;
        @(posedge clk);
        #1;
        check_val("mem_pattern", 64'(mem_bus()), 64'(5'b0_1010));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
